// File: rtl/jk_sched_pkg.sv
// Shared types and constants for the J-K clock-enable scheduler.
package jk_sched_pkg;

  localparam int DIV_W_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/jk_cen_chan.sv
// One scheduling channel: period counter, reload, preset/clear registering,
// strobe suppression and the drain-complete (frozen) flag.
module jk_cen_chan
  import jk_sched_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             active,
  input  logic             draining,
  input  logic             active_next,
  input  logic [DIV_W-1:0] div,
  input  logic [DIV_W-1:0] load_val,
  input  logic             preset_req_bar,
  input  logic             clear_req_bar,
  output logic             cen,
  output logic             preset_bar_o,
  output logic             clear_bar_o,
  output logic             frozen_next
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] cnt_next;
  logic             frozen;
  logic             supp;
  logic             emit;
  logic             preset_next;
  logic             clear_next;

  always_comb begin
    preset_next = preset_req_bar | ~clear_req_bar;
    clear_next  = clear_req_bar;
    supp        = ~(preset_bar_o & clear_bar_o);
    emit        = active & ~frozen & ~supp & (cnt == '0);
    cnt_next    = cnt;
    frozen_next = frozen;
    if (load) begin
      cnt_next    = load_val;
      frozen_next = 1'b0;
    end else if (active && !frozen) begin
      // A forced set/clear restarts the period just like a wrap does.
      if (supp || cnt == '0) cnt_next = div;
      else                   cnt_next = cnt - DIV_W'(1);
      if (draining && emit) frozen_next = 1'b1;
    end
  end

  // Cen is the registered form of "counter reads 0 next cycle and may strobe".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      frozen       <= 1'b0;
      cen          <= 1'b0;
      preset_bar_o <= 1'b1;
      clear_bar_o  <= 1'b1;
    end else begin
      cnt          <= cnt_next;
      frozen       <= frozen_next;
      preset_bar_o <= preset_next;
      clear_bar_o  <= clear_next;
      cen          <= active_next & ~frozen_next & preset_next & clear_next
                      & (cnt_next == '0);
    end
  end

endmodule

// File: rtl/jk_cen_sched.sv
// Clock-enable scheduler top: IDLE/ALIGN/RUN/DRAIN sequencer over BLOCKS channels.
// Optional macro JK_CEN_SCHED_PHASE_EN makes ALIGN load Phase instead of Div.
module jk_cen_sched
  import jk_sched_pkg::*;
#(
  parameter int BLOCKS = 2,
  parameter int DIV_W  = DIV_W_DEFAULT
) (
  input  logic                    Clk,
  input  logic                    Reset_bar,
  input  logic                    Start,
  input  logic                    Stop,
  input  logic [BLOCKS*DIV_W-1:0] Div,
  input  logic [BLOCKS*DIV_W-1:0] Phase,
  input  logic [BLOCKS-1:0]       Preset_req_bar,
  input  logic [BLOCKS-1:0]       Clear_req_bar,
  output logic [BLOCKS-1:0]       Cen,
  output logic [BLOCKS-1:0]       Preset_bar_o,
  output logic [BLOCKS-1:0]       Clear_bar_o,
  output logic                    Running
);

  state_t                  state;
  logic [BLOCKS-1:0]       frozen_next;
  logic                    all_frozen;
  logic                    load;
  logic                    active;
  logic                    draining;
  logic                    active_next;
  logic [BLOCKS*DIV_W-1:0] load_bus;

`ifdef JK_CEN_SCHED_PHASE_EN
  assign load_bus = Phase;
`else
  logic unused_phase;
  assign load_bus     = Div;
  assign unused_phase = ^Phase;
`endif

  assign all_frozen  = &frozen_next;
  assign load        = (state == ALIGN);
  assign active      = (state == RUN) || (state == DRAIN);
  assign draining    = (state == DRAIN);
  // Channels need to know whether the next cycle may strobe at all.
  assign active_next = load | (state == RUN) | (draining & ~all_frozen);

  always_ff @(posedge Clk or negedge Reset_bar) begin
    if (!Reset_bar) begin
      state   <= IDLE;
      Running <= 1'b0;
    end else begin
      case (state)
        IDLE:  if (Start) state <= ALIGN;
        ALIGN: begin
          state   <= RUN;
          Running <= 1'b1;
        end
        RUN:   if (Stop) state <= DRAIN;
        DRAIN: if (all_frozen) begin
          state   <= IDLE;
          Running <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          Running <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < BLOCKS; g++) begin : g_chan
    jk_cen_chan #(.DIV_W(DIV_W)) u_chan (
      .clk            (Clk),
      .rst_n          (Reset_bar),
      .load           (load),
      .active         (active),
      .draining       (draining),
      .active_next    (active_next),
      .div            (Div[g*DIV_W +: DIV_W]),
      .load_val       (load_bus[g*DIV_W +: DIV_W]),
      .preset_req_bar (Preset_req_bar[g]),
      .clear_req_bar  (Clear_req_bar[g]),
      .cen            (Cen[g]),
      .preset_bar_o   (Preset_bar_o[g]),
      .clear_bar_o    (Clear_bar_o[g]),
      .frozen_next    (frozen_next[g])
    );
  end

endmodule

// File: tb/tb_jk_cen_sched.sv
// Self-checking bench for jk_cen_sched: directed schedule scenarios plus a
// randomized run against an absolute-time schedule model.
module tb_jk_cen_sched;
  localparam int BLOCKS = 2;
  localparam int DIV_W  = 8;
  localparam int KW     = 8;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b0;
  logic                    start = 1'b0;
  logic                    stop = 1'b0;
  logic [BLOCKS*DIV_W-1:0] div_bus = '0;
  logic [BLOCKS*DIV_W-1:0] phase_bus = '0;
  logic [BLOCKS-1:0]       pre_req = '1;
  logic [BLOCKS-1:0]       clr_req = '1;
  logic [BLOCKS-1:0]       cen;
  logic [BLOCKS-1:0]       pre_o;
  logic [BLOCKS-1:0]       clr_o;
  logic                    running;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: mode 0 idle, 1 align, 2 run, 3 drain; strobe times are absolute k.
  int                m_mode;
  int                m_k;
  int                m_next [BLOCKS];
  bit                m_done [BLOCKS];
  logic [BLOCKS-1:0] exp_cen;
  logic [BLOCKS-1:0] exp_pre;
  logic [BLOCKS-1:0] exp_clr;
  logic              exp_run;
  logic [KW-1:0]     exp_q0[$];
  logic [KW-1:0]     exp_q1[$];

  always #5 clk = ~clk;

  jk_cen_sched #(.BLOCKS(BLOCKS), .DIV_W(DIV_W)) dut (
    .Clk            (clk),
    .Reset_bar      (rst_n),
    .Start          (start),
    .Stop           (stop),
    .Div            (div_bus),
    .Phase          (phase_bus),
    .Preset_req_bar (pre_req),
    .Clear_req_bar  (clr_req),
    .Cen            (cen),
    .Preset_bar_o   (pre_o),
    .Clear_bar_o    (clr_o),
    .Running        (running)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  function automatic int div_of(int c);
    return int'(div_bus[c*DIV_W +: DIV_W]);
  endfunction

  function automatic int load_of(int c);
`ifdef JK_CEN_SCHED_PHASE_EN
    return int'(phase_bus[c*DIV_W +: DIV_W]);
`else
    return int'(div_bus[c*DIV_W +: DIV_W]);
`endif
  endfunction

  task automatic set_div(input int c, input int v);
    div_bus[c*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  task automatic set_phase(input int c, input int v);
    phase_bus[c*DIV_W +: DIV_W] = DIV_W'(v);
  endtask

  task automatic model_reset();
    m_mode  = 0;
    m_k     = 0;
    exp_cen = '0;
    exp_pre = '1;
    exp_clr = '1;
    exp_run = 1'b0;
    for (int c = 0; c < BLOCKS; c++) begin
      m_next[c] = 0;
      m_done[c] = 1'b0;
    end
  endtask

  // Consume the current cycle's inputs and produce expectations for the next cycle.
  task automatic model_advance();
    int nm;
    bit all_done;
    bit supp;
    if (m_mode >= 2) begin
      for (int c = 0; c < BLOCKS; c++) begin
        if (!m_done[c]) begin
          supp = !(exp_pre[c] && exp_clr[c]);
          if (supp || m_k == m_next[c]) begin
            if (!supp && m_mode == 3) m_done[c] = 1'b1;
            m_next[c] = m_k + div_of(c) + 1;
          end
        end
      end
    end
    all_done = 1'b1;
    for (int c = 0; c < BLOCKS; c++) if (!m_done[c]) all_done = 1'b0;
    case (m_mode)
      0: nm = start ? 1 : 0;
      1: begin
        nm  = 2;
        m_k = -1;
        for (int c = 0; c < BLOCKS; c++) begin
          m_next[c] = load_of(c);
          m_done[c] = 1'b0;
        end
      end
      2: nm = stop ? 3 : 2;
      default: nm = all_done ? 0 : 3;
    endcase
    m_mode = nm;
    if (nm >= 2) m_k++;
    exp_clr = clr_req;
    exp_pre = pre_req | ~clr_req;
    exp_run = (nm >= 2);
    for (int c = 0; c < BLOCKS; c++)
      exp_cen[c] = (nm >= 2) && !m_done[c] && (m_k == m_next[c]) && exp_pre[c] && exp_clr[c];
  endtask

  task automatic tick();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    start   = 1'b0;
    stop    = 1'b0;
    pre_req = '1;
    clr_req = '1;
    rst_n   = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q0.delete();
    exp_q1.delete();
  endtask

  task automatic go_run();
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    pre_req = '0;
    clr_req = 2'b10;
    start   = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (cen !== 2'b00) $display("FAIL reset_cen actual=%b required=00", cen); else n_pass++;
    n_checks++; if (pre_o !== 2'b11) $display("FAIL reset_preset actual=%b required=11", pre_o); else n_pass++;
    n_checks++; if (clr_o !== 2'b11) $display("FAIL reset_clear actual=%b required=11", clr_o); else n_pass++;
    n_checks++; if (running !== 1'b0) $display("FAIL reset_running actual=%b required=0", running); else n_pass++;
    start   = 1'b0;
    pre_req = '1;
    clr_req = '1;
    rst_n   = 1'b1;
    tick();
    // Idle-state preset/clear latency and clear-over-preset priority.
    clr_req = 2'b01;
    pre_req = 2'b00;
    tick();
    n_checks++; if (clr_o !== 2'b01) $display("FAIL idle_clear actual=%b required=01", clr_o); else n_pass++;
    n_checks++; if (pre_o !== 2'b10) $display("FAIL idle_preset_prio actual=%b required=10", pre_o); else n_pass++;
    clr_req = '1;
    pre_req = '1;
    tick();
    n_checks++; if ({pre_o, clr_o} !== 4'b1111) $display("FAIL idle_release actual=%b required=1111", {pre_o, clr_o}); else n_pass++;
  endtask

  task automatic test_basic();
    logic [KW-1:0] e;
    int n1;
    apply_reset();
    set_div(0, 3);
    set_div(1, 0);
    set_phase(0, 3);
    set_phase(1, 0);
    exp_q0.push_back(8'd3); exp_q0.push_back(8'd7); exp_q0.push_back(8'd11);
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (running !== 1'b0) $display("FAIL basic_align_running actual=%b required=0", running); else n_pass++;
    tick();
    n_checks++; if (running !== 1'b1) $display("FAIL basic_run_t2 actual=%b required=1", running); else n_pass++;
    n1 = 0;
    for (int k = 0; k < 12; k++) begin
      n_checks++;
      if ({cen, running} !== {exp_cen, exp_run}) $display("FAIL basic_model k=%0d actual=%b required=%b", k, {cen, running}, {exp_cen, exp_run}); else n_pass++;
      if (cen[0]) begin
        n_checks++;
        if (exp_q0.size() == 0) $display("FAIL basic_cen0_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q0.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL basic_cen0_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      if (cen[1]) n1++;
      tick();
    end
    n_checks++; if (exp_q0.size() != 0) $display("FAIL basic_cen0_missing actual=%0d required=0", exp_q0.size()); else n_pass++;
    n_checks++; if (n1 != 12) $display("FAIL basic_cen1_count actual=%0d required=12", n1); else n_pass++;
  endtask

  task automatic test_div_change();
    logic [KW-1:0] e;
    apply_reset();
    set_div(0, 3);
    set_div(1, 5);
    set_phase(0, 3);
    set_phase(1, 5);
    exp_q0.push_back(8'd3); exp_q0.push_back(8'd5); exp_q0.push_back(8'd7);
    go_run();
    for (int k = 0; k < 8; k++) begin
      if (k == 1) set_div(0, 1);
      n_checks++;
      if ({cen, running} !== {exp_cen, exp_run}) $display("FAIL divchg_model k=%0d actual=%b required=%b", k, {cen, running}, {exp_cen, exp_run}); else n_pass++;
      if (cen[0]) begin
        n_checks++;
        if (exp_q0.size() == 0) $display("FAIL divchg_cen0_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q0.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL divchg_cen0_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      tick();
    end
    n_checks++; if (exp_q0.size() != 0) $display("FAIL divchg_cen0_missing actual=%0d required=0", exp_q0.size()); else n_pass++;
  endtask

  task automatic test_stop_drain();
    logic [KW-1:0] e;
    apply_reset();
    set_div(0, 3);
    set_div(1, 2);
    set_phase(0, 3);
    set_phase(1, 2);
    exp_q0.push_back(8'd3); exp_q0.push_back(8'd7);
    exp_q1.push_back(8'd2); exp_q1.push_back(8'd5); exp_q1.push_back(8'd8);
    go_run();
    for (int k = 0; k < 15; k++) begin
      stop = (k == 5);
      n_checks++;
      if (running !== (k <= 8)) $display("FAIL drain_running k=%0d actual=%b required=%b", k, running, (k <= 8)); else n_pass++;
      n_checks++;
      if (cen !== exp_cen) $display("FAIL drain_model k=%0d actual=%b required=%b", k, cen, exp_cen); else n_pass++;
      if (cen[0]) begin
        n_checks++;
        if (exp_q0.size() == 0) $display("FAIL drain_cen0_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q0.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL drain_cen0_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      if (cen[1]) begin
        n_checks++;
        if (exp_q1.size() == 0) $display("FAIL drain_cen1_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q1.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL drain_cen1_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      tick();
    end
    stop = 1'b0;
    n_checks++; if (exp_q0.size() + exp_q1.size() != 0) $display("FAIL drain_missing actual=%0d required=0", exp_q0.size() + exp_q1.size()); else n_pass++;
  endtask

  task automatic test_clear_preset();
    logic [KW-1:0] e;
    apply_reset();
    set_div(0, 3);
    set_div(1, 3);
    set_phase(0, 3);
    set_phase(1, 3);
    exp_q0.push_back(8'd7); exp_q0.push_back(8'd11);
    exp_q1.push_back(8'd3); exp_q1.push_back(8'd7); exp_q1.push_back(8'd13);
    go_run();
    for (int k = 0; k < 14; k++) begin
      pre_req = '1;
      clr_req = '1;
      if (k == 2) begin
        pre_req[0] = 1'b0;
        clr_req[0] = 1'b0;
      end
      if (k == 8) pre_req[1] = 1'b0;
      if (k == 3) begin
        n_checks++; if (clr_o[0] !== 1'b0) $display("FAIL cp_clear0 actual=%b required=0", clr_o[0]); else n_pass++;
        n_checks++; if (pre_o[0] !== 1'b1) $display("FAIL cp_preset0_prio actual=%b required=1", pre_o[0]); else n_pass++;
        n_checks++; if (cen[0] !== 1'b0) $display("FAIL cp_cen0_supp actual=%b required=0", cen[0]); else n_pass++;
      end
      if (k == 9) begin
        n_checks++; if ({pre_o[1], clr_o[1]} !== 2'b01) $display("FAIL cp_preset1 actual=%b required=01", {pre_o[1], clr_o[1]}); else n_pass++;
      end
      n_checks++;
      if ({cen, pre_o, clr_o} !== {exp_cen, exp_pre, exp_clr}) $display("FAIL cp_model k=%0d actual=%b required=%b", k, {cen, pre_o, clr_o}, {exp_cen, exp_pre, exp_clr}); else n_pass++;
      if (cen[0]) begin
        n_checks++;
        if (exp_q0.size() == 0) $display("FAIL cp_cen0_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q0.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL cp_cen0_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      if (cen[1]) begin
        n_checks++;
        if (exp_q1.size() == 0) $display("FAIL cp_cen1_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q1.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL cp_cen1_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      tick();
    end
    pre_req = '1;
    clr_req = '1;
    n_checks++; if (exp_q0.size() + exp_q1.size() != 0) $display("FAIL cp_missing actual=%0d required=0", exp_q0.size() + exp_q1.size()); else n_pass++;
  endtask

  task automatic test_reset_in_drain();
    apply_reset();
    set_div(0, 4);
    set_div(1, 4);
    set_phase(0, 4);
    set_phase(1, 4);
    go_run();
    for (int k = 0; k < 4; k++) begin
      stop = (k == 2);
      tick();
    end
    stop = 1'b0;
    n_checks++; if (cen !== 2'b11) $display("FAIL rd_drain_strobe actual=%b required=11", cen); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_checks++; if ({cen, pre_o, clr_o, running} !== 7'b0011110) $display("FAIL rd_async actual=%b required=0011110", {cen, pre_o, clr_o, running}); else n_pass++;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    n_checks++; if (running !== 1'b0) $display("FAIL rd_restart_align actual=%b required=0", running); else n_pass++;
    tick();
    n_checks++; if (running !== 1'b1) $display("FAIL rd_restart_run actual=%b required=1", running); else n_pass++;
    repeat (4) tick();
    n_checks++; if (cen !== 2'b11) $display("FAIL rd_restart_cen actual=%b required=11", cen); else n_pass++;
  endtask

  task automatic test_phase();
    logic [KW-1:0] e;
    apply_reset();
    set_div(0, 3);
    set_div(1, 3);
    set_phase(0, 3);
    set_phase(1, 1);
    exp_q0.push_back(8'd3); exp_q0.push_back(8'd7); exp_q0.push_back(8'd11);
`ifdef JK_CEN_SCHED_PHASE_EN
    exp_q1.push_back(8'd1); exp_q1.push_back(8'd5); exp_q1.push_back(8'd9);
`else
    exp_q1.push_back(8'd3); exp_q1.push_back(8'd7); exp_q1.push_back(8'd11);
`endif
    go_run();
    for (int k = 0; k < 12; k++) begin
      if (cen[0]) begin
        n_checks++;
        if (exp_q0.size() == 0) $display("FAIL phase_cen0_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q0.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL phase_cen0_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      if (cen[1]) begin
        n_checks++;
        if (exp_q1.size() == 0) $display("FAIL phase_cen1_extra k=%0d actual=1 required=0", k);
        else begin
          e = exp_q1.pop_front();
          if (e !== k[KW-1:0]) $display("FAIL phase_cen1_slot actual=%0d required=%0d", k, e); else n_pass++;
        end
      end
      tick();
    end
    n_checks++; if (exp_q0.size() + exp_q1.size() != 0) $display("FAIL phase_missing actual=%0d required=0", exp_q0.size() + exp_q1.size()); else n_pass++;
  endtask

  task automatic test_random();
    apply_reset();
    for (int c = 0; c < BLOCKS; c++) begin
      set_div(c, int'($urandom_range(0, 6)));
      set_phase(c, int'($urandom_range(0, 6)));
    end
    for (int i = 0; i < 1500; i++) begin
      n_checks++;
      if ({cen, pre_o, clr_o, running} !== {exp_cen, exp_pre, exp_clr, exp_run})
        $display("FAIL random_model cycle=%0d actual=%b required=%b", i, {cen, pre_o, clr_o, running}, {exp_cen, exp_pre, exp_clr, exp_run});
      else n_pass++;
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 24) == 0);
      for (int c = 0; c < BLOCKS; c++) begin
        pre_req[c] = ($urandom_range(0, 11) != 0);
        clr_req[c] = ($urandom_range(0, 13) != 0);
        if ($urandom_range(0, 19) == 0) set_div(c, int'($urandom_range(0, 6)));
        if ($urandom_range(0, 19) == 0) set_phase(c, int'($urandom_range(0, 6)));
      end
      tick();
    end
    start   = 1'b0;
    stop    = 1'b0;
    pre_req = '1;
    clr_req = '1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_change();
    test_stop_drain();
    test_clear_preset();
    test_reset_in_drain();
    test_phase();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
